// File: rtl/issue_queue.sv
// issue_queue: age-ordered, compacting issue queue for one execution cluster.
//
// Entries 0..count-1 are valid, entry 0 is the oldest. Each entry keeps the
// renamed instruction fields plus sticky per-source ready bits that are set by
// four wakeup ports. Every cycle the oldest fully-ready entry is offered to the
// execute unit, with operands read combinationally from the register file.
//
// Ports:
//   clk, rst (sync, active-low), flush
//   enq_*        dispatch -> queue instruction and handshake (enq_valid/enq_allowin)
//   wake_valid / wake_rd_phy   NWAKE wakeup ports, port i at [i*PHY_W +: PHY_W]
//   rf_rs1/2_addr out, rf_rs1/2_data in   register-file read port
//   iss_*        queue -> execute instruction and handshake (iss_valid/iss_allowin)
//
// Handshakes: a transfer happens on a rising edge where valid && allowin.
// enq_allowin depends only on registered state and flush; iss_valid depends only
// on registered state and flush, never on iss_allowin.
module issue_queue #(
  parameter int DEPTH  = 4,
  parameter int PHY_W  = 6,
  parameter int ROB_W  = 5,
  parameter int UOP_W  = 8,
  parameter int DATA_W = 32,
  parameter int NWAKE  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   enq_valid,
  output logic                   enq_allowin,
  input  logic [UOP_W-1:0]       enq_uop,
  input  logic [ROB_W-1:0]       enq_rob_id,
  input  logic [DATA_W-1:0]      enq_pc,
  input  logic [DATA_W-1:0]      enq_immediate,
  input  logic [PHY_W-1:0]       enq_rs1_phy,
  input  logic [PHY_W-1:0]       enq_rs2_phy,
  input  logic [PHY_W-1:0]       enq_rd_phy,
  input  logic                   enq_rs1_ready,
  input  logic                   enq_rs2_ready,
  input  logic [NWAKE-1:0]       wake_valid,
  input  logic [NWAKE*PHY_W-1:0] wake_rd_phy,
  output logic [PHY_W-1:0]       rf_rs1_addr,
  output logic [PHY_W-1:0]       rf_rs2_addr,
  input  logic [DATA_W-1:0]      rf_rs1_data,
  input  logic [DATA_W-1:0]      rf_rs2_data,
  output logic                   iss_valid,
  input  logic                   iss_allowin,
  output logic [UOP_W-1:0]       iss_uop,
  output logic [ROB_W-1:0]       iss_rob_id,
  output logic [PHY_W-1:0]       iss_rd_phy,
  output logic [DATA_W-1:0]      iss_pc,
  output logic [DATA_W-1:0]      iss_immediate,
  output logic [DATA_W-1:0]      iss_rs1_data,
  output logic [DATA_W-1:0]      iss_rs2_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [UOP_W-1:0]  uop;
    logic [ROB_W-1:0]  rob_id;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] immediate;
    logic [PHY_W-1:0]  rs1_phy;
    logic [PHY_W-1:0]  rs2_phy;
    logic [PHY_W-1:0]  rd_phy;
    logic              rs1_rdy;
    logic              rs2_rdy;
  } entry_t;

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  entry_t           woken   [DEPTH];
  entry_t           new_entry;
  entry_t           sel_entry;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] wr_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             pop;
  logic             accept;

  function automatic logic wake_hit(input logic [PHY_W-1:0]       phy,
                                    input logic [NWAKE-1:0]       wv,
                                    input logic [NWAKE*PHY_W-1:0] wp);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < NWAKE; w++) begin
      if (wv[w] && (wp[w*PHY_W +: PHY_W] == phy)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Oldest valid entry whose registered ready bits are both set. Same-cycle
  // wakeups are deliberately not considered here.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && (CNT_W'(i) < count_q) &&
          entry_q[i].rs1_rdy && entry_q[i].rs2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // With nothing selected sel_idx is 0, so the outputs show entry 0 (never X).
  assign sel_entry     = entry_q[sel_idx];
  assign enq_allowin   = (count_q < CNT_W'(DEPTH)) && !flush;
  assign iss_valid     = sel_found && !flush;
  assign accept        = enq_valid && enq_allowin;
  assign pop           = iss_valid && iss_allowin;
  assign rf_rs1_addr   = sel_entry.rs1_phy;
  assign rf_rs2_addr   = sel_entry.rs2_phy;
  assign iss_uop       = sel_entry.uop;
  assign iss_rob_id    = sel_entry.rob_id;
  assign iss_rd_phy    = sel_entry.rd_phy;
  assign iss_pc        = sel_entry.pc;
  assign iss_immediate = sel_entry.immediate;
  assign iss_rs1_data  = rf_rs1_data;
  assign iss_rs2_data  = rf_rs2_data;

  // Sticky wakeup applied to every stored entry before compaction.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = entry_q[i];
      if (wake_hit(entry_q[i].rs1_phy, wake_valid, wake_rd_phy)) woken[i].rs1_rdy = 1'b1;
      if (wake_hit(entry_q[i].rs2_phy, wake_valid, wake_rd_phy)) woken[i].rs2_rdy = 1'b1;
    end
  end

  always_comb begin
    new_entry           = '0;
    new_entry.uop       = enq_uop;
    new_entry.rob_id    = enq_rob_id;
    new_entry.pc        = enq_pc;
    new_entry.immediate = enq_immediate;
    new_entry.rs1_phy   = enq_rs1_phy;
    new_entry.rs2_phy   = enq_rs2_phy;
    new_entry.rd_phy    = enq_rd_phy;
    // A wakeup arriving with the instruction is captured so it is not lost.
    new_entry.rs1_rdy   = enq_rs1_ready || wake_hit(enq_rs1_phy, wake_valid, wake_rd_phy);
    new_entry.rs2_rdy   = enq_rs2_ready || wake_hit(enq_rs2_phy, wake_valid, wake_rd_phy);

    for (int i = 0; i < DEPTH; i++) entry_d[i] = woken[i];

    // Compaction: everything above the issued slot moves down one place.
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) entry_d[i] = woken[i+1];
      end
      entry_d[DEPTH-1] = '0;
    end

    // The new entry goes right after the last surviving entry.
    wr_idx = count_q - CNT_W'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (CNT_W'(i) == wr_idx)) entry_d[i] = new_entry;
    end

    count_d = count_q;
    if (flush)               count_d = '0;
    else if (accept && !pop) count_d = count_q + CNT_W'(1);
    else if (!accept && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed table of cycles, hand-written multi-cycle
// sequences (backpressure, flush, mid-stream reset), then random traffic
// compared against a queue-based reference model.
module tb_issue_queue;

  localparam int DEPTH  = 4;
  localparam int PHY_W  = 6;
  localparam int ROB_W  = 5;
  localparam int UOP_W  = 8;
  localparam int DATA_W = 32;
  localparam int NWAKE  = 4;
  localparam int REC_W  = ROB_W + UOP_W + PHY_W + 4*DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                   flush;
  logic                   enq_valid, enq_allowin;
  logic [UOP_W-1:0]       enq_uop;
  logic [ROB_W-1:0]       enq_rob_id;
  logic [DATA_W-1:0]      enq_pc, enq_immediate;
  logic [PHY_W-1:0]       enq_rs1_phy, enq_rs2_phy, enq_rd_phy;
  logic                   enq_rs1_ready, enq_rs2_ready;
  logic [NWAKE-1:0]       wake_valid;
  logic [NWAKE*PHY_W-1:0] wake_rd_phy;
  logic [PHY_W-1:0]       rf_rs1_addr, rf_rs2_addr;
  logic [DATA_W-1:0]      rf_rs1_data, rf_rs2_data;
  logic                   iss_valid, iss_allowin;
  logic [UOP_W-1:0]       iss_uop;
  logic [ROB_W-1:0]       iss_rob_id;
  logic [PHY_W-1:0]       iss_rd_phy;
  logic [DATA_W-1:0]      iss_pc, iss_immediate, iss_rs1_data, iss_rs2_data;

  // Register file stand-in: data encodes the address so operands are traceable.
  assign rf_rs1_data = 32'h1000_0000 | {{(DATA_W-PHY_W){1'b0}}, rf_rs1_addr};
  assign rf_rs2_data = 32'h2000_0000 | {{(DATA_W-PHY_W){1'b0}}, rf_rs2_addr};

  issue_queue #(.DEPTH(DEPTH), .PHY_W(PHY_W), .ROB_W(ROB_W), .UOP_W(UOP_W),
                .DATA_W(DATA_W), .NWAKE(NWAKE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_allowin(enq_allowin), .enq_uop(enq_uop),
    .enq_rob_id(enq_rob_id), .enq_pc(enq_pc), .enq_immediate(enq_immediate),
    .enq_rs1_phy(enq_rs1_phy), .enq_rs2_phy(enq_rs2_phy), .enq_rd_phy(enq_rd_phy),
    .enq_rs1_ready(enq_rs1_ready), .enq_rs2_ready(enq_rs2_ready),
    .wake_valid(wake_valid), .wake_rd_phy(wake_rd_phy),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .iss_valid(iss_valid), .iss_allowin(iss_allowin), .iss_uop(iss_uop),
    .iss_rob_id(iss_rob_id), .iss_rd_phy(iss_rd_phy), .iss_pc(iss_pc),
    .iss_immediate(iss_immediate), .iss_rs1_data(iss_rs1_data),
    .iss_rs2_data(iss_rs2_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush         = 1'b0;
    enq_valid     = 1'b0;
    enq_uop       = '0;
    enq_rob_id    = '0;
    enq_pc        = '0;
    enq_immediate = '0;
    enq_rs1_phy   = '0;
    enq_rs2_phy   = '0;
    enq_rd_phy    = '0;
    enq_rs1_ready = 1'b0;
    enq_rs2_ready = 1'b0;
    wake_valid    = '0;
    wake_rd_phy   = '0;
    iss_allowin   = 1'b0;
  endtask

  task automatic drive_enq(input logic [ROB_W-1:0] rob, input logic [PHY_W-1:0] rs1,
                           input logic [PHY_W-1:0] rs2, input logic r1, input logic r2);
    enq_valid     = 1'b1;
    enq_rob_id    = rob;
    enq_uop       = 8'h40 + UOP_W'(rob);
    enq_pc        = 32'h0000_1000 + 32'(rob) * 4;
    enq_immediate = 32'hFFFF_0000 | 32'(rob);
    enq_rd_phy    = 6'd32 + PHY_W'(rob);
    enq_rs1_phy   = rs1;
    enq_rs2_phy   = rs2;
    enq_rs1_ready = r1;
    enq_rs2_ready = r2;
  endtask

  task automatic drive_wake(input logic [NWAKE-1:0] wv, input logic [PHY_W-1:0] phy);
    wake_valid = wv;
    for (int w = 0; w < NWAKE; w++) wake_rd_phy[w*PHY_W +: PHY_W] = phy;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             en;
    logic [ROB_W-1:0] rob;
    logic [PHY_W-1:0] rs1, rs2;
    logic             r1, r2;
    logic [NWAKE-1:0] wv;
    logic [PHY_W-1:0] wphy;
    logic             ia;
    logic             e_allow, e_valid;
    logic [ROB_W-1:0] e_rob;
    logic [2:0]       e_cnt;   // count after the edge
  } vec_t;

  localparam int NVEC = 25;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic en, input int rob, input int rs1, input int rs2,
                              input logic r1, input logic r2, input logic [3:0] wv,
                              input int wphy, input logic ia, input logic ea,
                              input logic ev, input int erob, input int ecnt);
    vec_t v;
    v.en = en; v.rob = ROB_W'(rob); v.rs1 = PHY_W'(rs1); v.rs2 = PHY_W'(rs2);
    v.r1 = r1; v.r2 = r2; v.wv = wv; v.wphy = PHY_W'(wphy); v.ia = ia;
    v.e_allow = ea; v.e_valid = ev; v.e_rob = ROB_W'(erob); v.e_cnt = 3'(ecnt);
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [UOP_W-1:0]  uop;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] pc, imm;
    logic [PHY_W-1:0]  rs1, rs2, rd;
    logic              r1, r2;
  } m_ent_t;

  m_ent_t m_q[$];                 // index 0 = oldest
  logic [REC_W-1:0] exp_q[$];     // expected issue records

  function automatic logic m_woke(input logic [PHY_W-1:0] p);
    for (int w = 0; w < NWAKE; w++)
      if (wake_valid[w] && wake_rd_phy[w*PHY_W +: PHY_W] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_sel();
    foreach (m_q[i]) if (m_q[i].r1 && m_q[i].r2) return i;
    return -1;
  endfunction

  task automatic m_update();
    m_ent_t e;
    int     s;
    logic   pop_m, acc_m;
    s     = m_sel();
    pop_m = (s >= 0) && !flush && iss_allowin;
    acc_m = enq_valid && (m_q.size() < DEPTH) && !flush;
    if (!rst || flush) begin
      m_q.delete();
    end else begin
      foreach (m_q[i]) begin
        if (m_woke(m_q[i].rs1)) m_q[i].r1 = 1'b1;
        if (m_woke(m_q[i].rs2)) m_q[i].r2 = 1'b1;
      end
      if (pop_m) m_q.delete(s);
      if (acc_m) begin
        e.uop = enq_uop; e.rob = enq_rob_id; e.pc = enq_pc; e.imm = enq_immediate;
        e.rs1 = enq_rs1_phy; e.rs2 = enq_rs2_phy; e.rd = enq_rd_phy;
        e.r1  = enq_rs1_ready || m_woke(enq_rs1_phy);
        e.r2  = enq_rs2_ready || m_woke(enq_rs2_phy);
        m_q.push_back(e);
      end
    end
  endtask

  task automatic rand_cycle();
    int               s;
    logic             exp_valid;
    logic [REC_W-1:0] got;
    // drive
    drive_idle();
    rst       = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
    flush     = ($urandom_range(0, 39) == 0);
    enq_valid = $urandom_range(0, 1);
    enq_uop = UOP_W'($urandom); enq_rob_id = ROB_W'($urandom);
    enq_pc = $urandom; enq_immediate = $urandom; enq_rd_phy = PHY_W'($urandom);
    enq_rs1_phy = PHY_W'($urandom_range(0, 7));
    enq_rs2_phy = PHY_W'($urandom_range(0, 7));
    enq_rs1_ready = ($urandom_range(0, 2) == 0);
    enq_rs2_ready = ($urandom_range(0, 2) == 0);
    for (int w = 0; w < NWAKE; w++) begin
      wake_valid[w] = ($urandom_range(0, 3) == 0);
      wake_rd_phy[w*PHY_W +: PHY_W] = PHY_W'($urandom_range(0, 7));
    end
    iss_allowin = $urandom_range(0, 1);
    // sample
    @(negedge clk);
    s         = m_sel();
    exp_valid = (s >= 0) && !flush;
    chk("rnd_iss_valid", iss_valid, exp_valid);
    chk("rnd_enq_allowin", enq_allowin, (m_q.size() < DEPTH) && !flush);
    if (exp_valid)
      exp_q.push_back({m_q[s].rob, m_q[s].uop, m_q[s].rd, m_q[s].pc, m_q[s].imm,
                       32'h1000_0000 | 32'(m_q[s].rs1), 32'h2000_0000 | 32'(m_q[s].rs2)});
    if (iss_valid) begin
      got = {iss_rob_id, iss_uop, iss_rd_phy, iss_pc, iss_immediate, iss_rs1_data, iss_rs2_data};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rnd_issue_record: got %0h expected no issue", got);
      end else if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL rnd_issue_record: got %0h expected %0h", got, exp_q[0]);
      end
    end
    exp_q.delete();
    // edge
    @(posedge clk);
    m_update();
    #1;
    chk("rnd_count", 64'(dut.count_q), 64'(m_q.size()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    //            en rob rs1 rs2 r1 r2 wv       wphy ia  ea ev erob cnt
    tbl[0]  = mk(1,  3,  1,  2, 1, 1, 4'b0000, 0,  1,  1, 0,  0, 1);
    tbl[1]  = mk(0,  0,  0,  0, 0, 0, 4'b0000, 0,  1,  1, 1,  3, 0);
    tbl[2]  = mk(1,  4,  7,  2, 0, 1, 4'b0000, 0,  1,  1, 0,  0, 1);
    tbl[3]  = mk(1,  5,  3,  4, 1, 1, 4'b0000, 0,  1,  1, 0,  0, 2);
    tbl[4]  = mk(0,  0,  0,  0, 0, 0, 4'b0100, 7,  1,  1, 1,  5, 1);
    tbl[5]  = mk(0,  0,  0,  0, 0, 0, 4'b0000, 0,  1,  1, 1,  4, 0);
    tbl[6]  = mk(1,  6,  1,  9, 1, 0, 4'b0001, 9,  1,  1, 0,  0, 1);
    tbl[7]  = mk(0,  0,  0,  0, 0, 0, 4'b0000, 0,  1,  1, 1,  6, 0);
    tbl[8]  = mk(1,  8, 20,  2, 0, 1, 4'b0000, 0,  1,  1, 0,  0, 1);
    tbl[9]  = mk(1,  9, 21,  2, 0, 1, 4'b0000, 0,  1,  1, 0,  0, 2);
    tbl[10] = mk(1, 10, 22,  2, 0, 1, 4'b0000, 0,  1,  1, 0,  0, 3);
    tbl[11] = mk(1, 11, 23,  2, 0, 1, 4'b0000, 0,  1,  1, 0,  0, 4);
    tbl[12] = mk(0,  0,  0,  0, 0, 0, 4'b0010, 22, 1,  0, 0,  0, 4);
    tbl[13] = mk(1, 12,  1,  2, 1, 1, 4'b0000, 0,  1,  0, 1, 10, 3);
    tbl[14] = mk(0,  0,  0,  0, 0, 0, 4'b1000, 20, 1,  1, 0,  0, 3);
    tbl[15] = mk(1, 13,  1,  2, 1, 1, 4'b0000, 0,  1,  1, 1,  8, 3);
    tbl[16] = mk(0,  0,  0,  0, 0, 0, 4'b0000, 0,  0,  1, 1, 13, 3);
    tbl[17] = mk(0,  0,  0,  0, 0, 0, 4'b0001, 21, 0,  1, 1, 13, 3);
    tbl[18] = mk(0,  0,  0,  0, 0, 0, 4'b0000, 0,  1,  1, 1,  9, 2);
    tbl[19] = mk(0,  0,  0,  0, 0, 0, 4'b0000, 0,  1,  1, 1, 13, 1);
    tbl[20] = mk(0,  0,  0,  0, 0, 0, 4'b1111, 23, 1,  1, 0,  0, 1);
    tbl[21] = mk(0,  0,  0,  0, 0, 0, 4'b0000, 0,  1,  1, 1, 11, 0);
    tbl[22] = mk(1, 14, 30, 30, 0, 0, 4'b0000, 0,  1,  1, 0,  0, 1);
    tbl[23] = mk(0,  0,  0,  0, 0, 0, 4'b0010, 30, 1,  1, 0,  0, 1);
    tbl[24] = mk(0,  0,  0,  0, 0, 0, 4'b0000, 0,  1,  1, 1, 14, 0);

    drive_idle();
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_enq_allowin", enq_allowin, 1);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_rob_id", iss_rob_id, 0);
    chk("rst_iss_uop", iss_uop, 0);
    chk("rst_iss_pc", iss_pc, 0);
    chk("rst_rf_rs1_addr", rf_rs1_addr, 0);
    chk("rst_count", 64'(dut.count_q), 0);
    rst = 1'b1;
    tick();

    // Directed table
    for (int k = 0; k < NVEC; k++) begin
      drive_idle();
      if (tbl[k].en) drive_enq(tbl[k].rob, tbl[k].rs1, tbl[k].rs2, tbl[k].r1, tbl[k].r2);
      drive_wake(tbl[k].wv, tbl[k].wphy);
      iss_allowin = tbl[k].ia;
      @(negedge clk);
      chk($sformatf("vec%0d_enq_allowin", k), enq_allowin, tbl[k].e_allow);
      chk($sformatf("vec%0d_iss_valid", k), iss_valid, tbl[k].e_valid);
      if (tbl[k].e_valid) chk($sformatf("vec%0d_iss_rob_id", k), iss_rob_id, tbl[k].e_rob);
      tick();
      chk($sformatf("vec%0d_count", k), 64'(dut.count_q), 64'(tbl[k].e_cnt));
    end

    // Backpressure: held offer stays valid and stable
    drive_idle();
    drive_enq(5'd20, 6'd5, 6'd6, 1'b1, 1'b1);
    tick();
    drive_idle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_iss_valid", iss_valid, 1);
      chk("bp_iss_rob_id", iss_rob_id, 20);
      chk("bp_rf_rs1_addr", rf_rs1_addr, 5);
      chk("bp_iss_rs2_data", iss_rs2_data, 32'h2000_0006);
      chk("bp_iss_pc", iss_pc, 32'h0000_1050);
      tick();
      chk("bp_count", 64'(dut.count_q), 1);
    end
    iss_allowin = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", iss_valid, 1);
    tick();
    chk("bp_release_count", 64'(dut.count_q), 0);

    // Flush with three entries; enqueue during flush must be ignored
    drive_idle();
    drive_enq(5'd21, 6'd1, 6'd2, 1'b1, 1'b1); tick();
    drive_enq(5'd22, 6'd40, 6'd2, 1'b0, 1'b1); tick();
    drive_enq(5'd23, 6'd41, 6'd2, 1'b0, 1'b1); tick();
    drive_idle();
    chk("fl_pre_count", 64'(dut.count_q), 3);
    flush = 1'b1;
    iss_allowin = 1'b1;
    drive_enq(5'd24, 6'd1, 6'd2, 1'b1, 1'b1);
    @(negedge clk);
    chk("fl_iss_valid", iss_valid, 0);
    chk("fl_enq_allowin", enq_allowin, 0);
    tick();
    chk("fl_count", 64'(dut.count_q), 0);
    drive_idle();
    @(negedge clk);
    chk("fl_after_iss_valid", iss_valid, 0);
    chk("fl_after_enq_allowin", enq_allowin, 1);
    tick();

    // Reset mid-stream discards everything regardless of handshakes
    drive_enq(5'd25, 6'd1, 6'd2, 1'b1, 1'b1); tick();
    drive_enq(5'd26, 6'd1, 6'd2, 1'b1, 1'b1); tick();
    drive_enq(5'd27, 6'd1, 6'd2, 1'b1, 1'b1); tick();
    drive_idle();
    @(negedge clk);
    chk("mr_pre_iss_rob_id", iss_rob_id, 25);
    chk("mr_pre_count", 64'(dut.count_q), 3);
    rst = 1'b0;
    iss_allowin = 1'b1;
    drive_enq(5'd28, 6'd1, 6'd2, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    drive_idle();
    chk("mr_count", 64'(dut.count_q), 0);
    @(negedge clk);
    chk("mr_iss_valid", iss_valid, 0);
    chk("mr_enq_allowin", enq_allowin, 1);
    chk("mr_iss_rob_id", iss_rob_id, 0);
    tick();

    // Random traffic against the model
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_q.delete();
    exp_q.delete();
    for (int n = 0; n < 1500; n++) rand_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
